// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and widths for the mux select scanner.
package mux_scan_pkg;
    localparam int SEL_W  = 2;
    localparam int WORD_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_HOLD} scan_state_t;

    function automatic logic word_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction
endpackage

// File: rtl/mux_scan_sampler_if.sv
// Downstream word handshake. Optional MUX_SCAN_PARITY_EN adds word_par.
interface mux_scan_sampler_if;
    import mux_scan_pkg::*;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              word_ready;
`ifdef MUX_SCAN_PARITY_EN
    logic              word_par;
`endif

    modport master (
        output word, word_valid,
`ifdef MUX_SCAN_PARITY_EN
        output word_par,
`endif
        input  word_ready
    );
    modport slave (
        input  word, word_valid,
`ifdef MUX_SCAN_PARITY_EN
        input  word_par,
`endif
        output word_ready
    );
endinterface

// File: rtl/mux_scan_sampler_settle_cnt.sv
// Settle-time down-counter: done pulses on the last cycle of each hold period.
module mux_scan_settle_cnt #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic done
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_cnt <= LOAD;
        else if (clr || (en && r_cnt == '0)) r_cnt <= LOAD;
        else if (en)                         r_cnt <= r_cnt - 1'b1;
    end

    assign done = en && (r_cnt == '0);
endmodule

// File: rtl/mux_scan_sampler.sv
// Sweeps a 4:1 mux select, samples its output per select, delivers {d,c,b,a}.
// Optional MUX_SCAN_PARITY_EN adds registered parity output word_par.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC      = 2,
    parameter bit SCAN_CONTINUOUS = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                S0,
    output logic                S1,
    input  logic                mux_in,
    output logic                busy,
    output logic                overrun,
    mux_scan_sampler_if.master  bus
);
    scan_state_t       r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [WORD_W-1:0] r_shadow, r_word;
    logic              r_valid, r_busy, r_overrun;
    logic              w_done, w_accept, w_free, w_last;
    logic [WORD_W-1:0] w_sweep;
`ifdef MUX_SCAN_PARITY_EN
    logic              r_par;
`endif

    mux_scan_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_state == ST_SCAN),
        .clr   (r_state != ST_SCAN),
        .done  (w_done)
    );

    assign w_accept = r_valid && bus.word_ready;
    assign w_free   = !r_valid || bus.word_ready;
    assign w_last   = (r_sel == SEL_W'(WORD_W - 1));

    // Shadow with the current select's sample merged in; on the last select this is the full word.
    always_comb begin
        w_sweep        = r_shadow;
        w_sweep[r_sel] = mux_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_shadow  <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            if (w_accept) r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_SCAN;
                    r_sel   <= '0;
                    r_busy  <= 1'b1;
                end
                ST_SCAN: if (w_done) begin
                    r_shadow <= w_sweep;
                    r_sel    <= r_sel + 1'b1;
                    if (w_last) begin
                        if (w_free) begin
                            r_word  <= w_sweep;
                            r_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                            r_par   <= word_parity(w_sweep);
`endif
                            if (!SCAN_CONTINUOUS) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else if (SCAN_CONTINUOUS) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: if (w_accept) begin
                    r_word  <= r_shadow;
                    r_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    r_par   <= word_parity(r_shadow);
`endif
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign S0             = r_sel[0];
    assign S1             = r_sel[1];
    assign busy           = r_busy;
    assign overrun        = r_overrun;
    assign bus.word       = r_word;
    assign bus.word_valid = r_valid;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.word_par   = r_par;
`endif
endmodule
